// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one bit per cycle, with a start/busy/done handshake.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start_i,
    input  logic [2:0]       MDU_Operation_i,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    output logic             Busy_o,
    output logic             Done_o,
    output logic [WIDTH-1:0] Result_o,
    output logic             Zero_o
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, PREP, CALC, FIN} state_t;

    state_t             state_reg, state_next;
    logic [2:0]         op_reg, op_next;
    logic [WIDTH-1:0]   a_reg, a_next, b_reg, b_next;
    logic [WIDTH-1:0]   operand_reg, operand_next;
    logic [2*WIDTH-1:0] acc_reg, acc_next;
    logic               neg_reg, neg_next;
    logic [CW-1:0]      cnt_reg, cnt_next;
    logic [WIDTH-1:0]   result_reg, result_next;
    logic               zero_reg, zero_next, done_reg, done_next;

    // Operand classification and magnitudes
    logic             is_div, is_rem, a_signed, b_signed, sign_a, sign_b;
    logic             div_zero, overflow;
    logic [WIDTH-1:0] mag_a, mag_b;

    assign is_div   = op_reg[2];
    assign is_rem   = op_reg[2] & op_reg[1];
    assign a_signed = (op_reg == 3'b001) | (op_reg == 3'b010) | (op_reg == 3'b100) | (op_reg == 3'b110);
    assign b_signed = (op_reg == 3'b001) | (op_reg == 3'b100) | (op_reg == 3'b110);
    assign sign_a   = a_signed & a_reg[WIDTH-1];
    assign sign_b   = b_signed & b_reg[WIDTH-1];
    assign mag_a    = sign_a ? -a_reg : a_reg;
    assign mag_b    = sign_b ? -b_reg : b_reg;
    assign div_zero = (b_reg == '0);
    assign overflow = ~op_reg[0] & (a_reg == MIN_VAL) & (b_reg == '1);

    // acc holds {partial product, multiplier} for multiply and {remainder, quotient} for divide
    logic [WIDTH-1:0]   acc_hi, acc_lo;
    logic [WIDTH:0]     add_sum, partial, shifted, diff;
    logic               ge;
    logic [2*WIDTH-1:0] mul_step, div_step, full_fin;
    logic [WIDTH-1:0]   quo_fin, rem_fin, fin_result;

    assign acc_hi   = acc_reg[2*WIDTH-1:WIDTH];
    assign acc_lo   = acc_reg[WIDTH-1:0];
    assign add_sum  = {1'b0, acc_hi} + {1'b0, operand_reg};
    assign partial  = acc_lo[0] ? add_sum : {1'b0, acc_hi};
    assign mul_step = {partial, acc_lo[WIDTH-1:1]};
    assign shifted  = {acc_hi, acc_lo[WIDTH-1]};
    assign diff     = shifted - {1'b0, operand_reg};
    assign ge       = ~diff[WIDTH];
    assign div_step = {(ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0]), acc_lo[WIDTH-2:0], ge};

    assign full_fin = neg_reg ? -acc_reg : acc_reg;
    assign quo_fin  = neg_reg ? -acc_lo : acc_lo;
    assign rem_fin  = neg_reg ? -acc_hi : acc_hi;

    always_comb begin
        fin_result = full_fin[2*WIDTH-1:WIDTH];
        if (is_rem)
            fin_result = rem_fin;
        else if (is_div)
            fin_result = quo_fin;
        else if (op_reg == 3'b000)
            fin_result = full_fin[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (!reset)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next   = state_reg;
        op_next      = op_reg;
        a_next       = a_reg;
        b_next       = b_reg;
        operand_next = operand_reg;
        acc_next     = acc_reg;
        neg_next     = neg_reg;
        cnt_next     = cnt_reg;
        result_next  = result_reg;
        zero_next    = zero_reg;
        done_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (Start_i) begin
                    op_next    = MDU_Operation_i;
                    a_next     = A_i;
                    b_next     = B_i;
                    state_next = PREP;
                end
            end
            PREP: begin
                cnt_next = CW'(WIDTH - 1);
                // Special cases preload {remainder, quotient} with the final answer
                if (is_div && div_zero) begin
                    acc_next   = {a_reg, {WIDTH{1'b1}}};
                    neg_next   = 1'b0;
                    state_next = FIN;
                end else if (is_div && overflow) begin
                    acc_next   = {{WIDTH{1'b0}}, a_reg};
                    neg_next   = 1'b0;
                    state_next = FIN;
                end else begin
                    neg_next     = is_rem ? sign_a : (sign_a ^ sign_b);
                    operand_next = is_div ? mag_b : mag_a;
                    acc_next     = {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
                    state_next   = CALC;
                end
            end
            CALC: begin
                acc_next = is_div ? div_step : mul_step;
                if (cnt_reg == '0)
                    state_next = FIN;
                else
                    cnt_next = cnt_reg - CW'(1);
            end
            FIN: begin
                result_next = fin_result;
                zero_next   = (fin_result == '0);
                done_next   = 1'b1;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            op_reg      <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            operand_reg <= '0;
            acc_reg     <= '0;
            neg_reg     <= 1'b0;
            cnt_reg     <= '0;
            result_reg  <= '0;
            zero_reg    <= 1'b1;
            done_reg    <= 1'b0;
        end else begin
            op_reg      <= op_next;
            a_reg       <= a_next;
            b_reg       <= b_next;
            operand_reg <= operand_next;
            acc_reg     <= acc_next;
            neg_reg     <= neg_next;
            cnt_reg     <= cnt_next;
            result_reg  <= result_next;
            zero_reg    <= zero_next;
            done_reg    <= done_next;
        end
    end

    assign Busy_o   = (state_reg != IDLE);
    assign Done_o   = done_reg;
    assign Result_o = result_reg;
    assign Zero_o   = zero_reg;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: expected results queued at issue, checked when Done_o fires.
module tb_mul_div_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        Start_i = 1'b0;
    logic [2:0]  MDU_Operation_i = 3'b000;
    logic [31:0] A_i = '0;
    logic [31:0] B_i = '0;
    logic        Busy_o, Done_o, Zero_o;
    logic [31:0] Result_o;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int snap;
    logic [31:0] exp_q[$];

    localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
    localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .Start_i(Start_i), .MDU_Operation_i(MDU_Operation_i),
        .A_i(A_i), .B_i(B_i), .Busy_o(Busy_o), .Done_o(Done_o),
        .Result_o(Result_o), .Zero_o(Zero_o)
    );

    always #5 clk = ~clk;

    // Done_o is sampled before the edge updates it, so each pulse counts once
    always @(posedge clk) if (Done_o) done_cnt <= done_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res);
        Start_i = 1'b1;
        MDU_Operation_i = op;
        A_i = a;
        B_i = b;
        exp_q.push_back(exp_res);
    endtask

    // Called right after the capture edge; returns at the negedge where Done_o is high
    task automatic wait_done(input int init_lat, input int exp_lat, input string tag);
        int lat = init_lat;
        bit seen = 1'b0;
        logic [31:0] exp_res;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            Start_i = 1'b0;
            A_i = $urandom;
            B_i = $urandom;
            MDU_Operation_i = 3'($urandom_range(7));
            if (Done_o) begin
                seen = 1'b1;
                break;
            end
            if (lat == 0) check({tag, "_busy"}, {31'b0, Busy_o}, 32'd1);
            lat++;
        end
        check({tag, "_done_seen"}, {31'b0, seen}, 32'd1);
        if (seen) check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 32'd0, 32'(exp_q.size() + 1));
        end else begin
            exp_res = exp_q.pop_front();
            if (seen) begin
                check({tag, "_result"}, Result_o, exp_res);
                check({tag, "_zero"}, {31'b0, Zero_o}, {31'b0, (exp_res == 32'd0)});
                $display("op %s result=%h expected=%h latency=%0d", tag, Result_o, exp_res, lat);
            end
        end
    endtask

    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input int exp_lat, input string tag);
        @(negedge clk);
        issue(op, a, b, exp_res);
        @(posedge clk);
        wait_done(0, exp_lat, tag);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", {31'b0, Busy_o}, 32'd0);
        check("rst_done", {31'b0, Done_o}, 32'd0);
        check("rst_result", Result_o, 32'd0);
        check("rst_zero", {31'b0, Zero_o}, 32'd1);
        reset = 1'b1;

        do_op(MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 34, "mul_7_m3");
        @(negedge clk);
        check("mul_done_width", {31'b0, Done_o}, 32'd0);

        do_op(MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, "mulhu_max");
        do_op(MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 34, "mulh_m1_m1");
        do_op(MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 34, "mulhsu_m1_2");
        do_op(MULH,   32'h80000000, 32'h80000000, 32'h40000000, 34, "mulh_min_min");
        do_op(DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, "div_m7_2");
        do_op(REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, "rem_m7_2");
        do_op(DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34, "div_7_m2");
        do_op(REM,    32'd7,        32'hFFFFFFFE, 32'd1,        34, "rem_7_m2");
        do_op(DIVU,   32'd100,      32'd7,        32'd14,       34, "divu_100_7");
        do_op(REMU,   32'd100,      32'd7,        32'd2,        34, "remu_100_7");
        do_op(DIVU,   32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 34, "divu_max_1");
        do_op(DIVU,   32'h80000000, 32'd3,        32'h2AAAAAAA, 34, "divu_min_3");

        do_op(DIVU, 32'd5,        32'd0,        32'hFFFFFFFF, 2, "divu_by0");
        do_op(REM,  32'd5,        32'd0,        32'd5,        2, "rem_by0");
        do_op(DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2, "div_ovf");
        do_op(REM,  32'h80000000, 32'hFFFFFFFF, 32'd0,        2, "rem_ovf");

        // Start pulse mid-CALC must be ignored
        @(negedge clk);
        issue(DIVU, 32'd100, 32'd7, 32'd14);
        @(posedge clk);
        repeat (10) begin
            @(negedge clk);
            Start_i = 1'b0;
        end
        @(negedge clk);
        Start_i = 1'b1;
        MDU_Operation_i = MUL;
        A_i = 32'd3;
        B_i = 32'd5;
        wait_done(11, 34, "ignore_start");
        @(negedge clk);
        snap = done_cnt;
        repeat (45) @(negedge clk);
        check("ignore_no_extra_done", 32'(done_cnt), 32'(snap));
        check("ignore_idle", {31'b0, Busy_o}, 32'd0);

        // Back-to-back: new Start_i in the Done_o cycle
        do_op(MUL, 32'd6, 32'd7, 32'd42, 34, "b2b_first");
        issue(REMU, 32'd100, 32'd7, 32'd2);
        @(posedge clk);
        wait_done(0, 34, "b2b_second");

        // Reset mid-CALC aborts the operation without a Done_o
        @(negedge clk);
        issue(MUL, 32'd9, 32'd9, 32'd81);
        @(posedge clk);
        repeat (10) begin
            @(negedge clk);
            Start_i = 1'b0;
        end
        snap = done_cnt;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        void'(exp_q.pop_back());
        check("abort_busy", {31'b0, Busy_o}, 32'd0);
        check("abort_result", Result_o, 32'd0);
        check("abort_zero", {31'b0, Zero_o}, 32'd1);
        repeat (40) @(negedge clk);
        check("abort_no_done", 32'(done_cnt), 32'(snap));
        do_op(MUL, 32'd9, 32'd9, 32'd81, 34, "after_abort");

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
